// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : seq_alu                                                           |
// | Multi-cycle MIPS ALU: registered single-cycle ops plus iterative           |
// | MULT/MULTU/DIV/DIVU into HI/LO, with valid/ready on both sides.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [4:0] c_opNop   = 5'd0;
  localparam logic [4:0] c_opAdd   = 5'd1;
  localparam logic [4:0] c_opSub   = 5'd2;
  localparam logic [4:0] c_opAnd   = 5'd3;
  localparam logic [4:0] c_opOr    = 5'd4;
  localparam logic [4:0] c_opSlt   = 5'd5;
  localparam logic [4:0] c_opSltu  = 5'd6;
  localparam logic [4:0] c_opAddu  = 5'd7;
  localparam logic [4:0] c_opSubu  = 5'd8;
  localparam logic [4:0] c_opXor   = 5'd9;
  localparam logic [4:0] c_opNor   = 5'd10;
  localparam logic [4:0] c_opSll   = 5'd11;
  localparam logic [4:0] c_opSrl   = 5'd12;
  localparam logic [4:0] c_opSra   = 5'd13;
  localparam logic [4:0] c_opLui   = 5'd14;
  localparam logic [4:0] c_opEql   = 5'd15;
  localparam logic [4:0] c_opBne   = 5'd16;
  localparam logic [4:0] c_opMult  = 5'd17;
  localparam logic [4:0] c_opMultu = 5'd18;
  localparam logic [4:0] c_opDiv   = 5'd19;
  localparam logic [4:0] c_opDivu  = 5'd20;
  localparam logic [4:0] c_opMfhi  = 5'd21;
  localparam logic [4:0] c_opMflo  = 5'd22;

  localparam int               CNT_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_luiMask = WIDTH'(17'h0FFFF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_stateNext;

  logic [WIDTH-1:0] r_result, r_hi, r_lo, r_hiPart, r_loPart, r_opB;
  logic             r_outValid, r_zero, r_ovf, r_negRes, r_negRem;
  logic [CNT_W-1:0] r_cnt;

  logic               w_accept, w_isMul, w_isDiv, w_isSigned, w_divZero, w_isLong, w_lastIter, w_busy;
  logic [WIDTH-1:0]   w_magA, w_magB, w_sum, w_diff, w_aluRes;
  logic               w_aluOvf;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_mulSum, w_divShift;
  logic [WIDTH-1:0]   w_divDiff, w_nextHi, w_nextLo, w_finalHi, w_finalLo;
  logic               w_divFits;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;

  assign w_busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign busy_o      = w_busy;
  assign in_ready_o  = (r_state == S_IDLE) && (!r_outValid || out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign out_valid_o = r_outValid;
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign ovf_o       = r_ovf;

  assign w_isMul    = (op_i == c_opMult) || (op_i == c_opMultu);
  assign w_isDiv    = (op_i == c_opDiv) || (op_i == c_opDivu);
  assign w_isSigned = (op_i == c_opMult) || (op_i == c_opDiv);
  assign w_divZero  = w_isDiv && (b_i == '0);
  assign w_isLong   = w_isMul || (w_isDiv && !w_divZero);
  assign w_magA     = (w_isSigned && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_magB     = (w_isSigned && b_i[WIDTH-1]) ? -b_i : b_i;
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_shamt  = a_i[SHAMT_W-1:0];
    w_sum    = a_i + b_i;
    w_diff   = a_i - b_i;
    w_aluRes = '0;
    w_aluOvf = 1'b0;
    case (op_i)
      c_opAdd: begin
        w_aluRes = w_sum;
        w_aluOvf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      c_opSub: begin
        w_aluRes = w_diff;
        w_aluOvf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      c_opAddu: w_aluRes = w_sum;
      c_opSubu: w_aluRes = w_diff;
      c_opAnd:  w_aluRes = a_i & b_i;
      c_opOr:   w_aluRes = a_i | b_i;
      c_opXor:  w_aluRes = a_i ^ b_i;
      c_opNor:  w_aluRes = ~(a_i | b_i);
      c_opSlt:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      c_opSltu: w_aluRes = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      c_opEql:  w_aluRes = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      c_opBne:  w_aluRes = {{(WIDTH-1){1'b0}}, (a_i != b_i)};
      c_opLui:  w_aluRes = (b_i & c_luiMask) << 16;
      c_opSll:  w_aluRes = b_i << w_shamt;
      c_opSrl:  w_aluRes = b_i >> w_shamt;
      c_opSra:  w_aluRes = $signed(b_i) >>> w_shamt;
      c_opMfhi: w_aluRes = r_hi;
      c_opMflo: w_aluRes = r_lo;
      default:  w_aluRes = '0;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide with the
  // remainder in r_hiPart and dividend/quotient shifting through r_loPart.
  always_comb begin
    w_mulSum   = {1'b0, r_hiPart} + (r_loPart[0] ? {1'b0, r_opB} : '0);
    w_divShift = {r_hiPart, r_loPart[WIDTH-1]};
    w_divFits  = (w_divShift >= {1'b0, r_opB});
    w_divDiff  = w_divShift[WIDTH-1:0] - r_opB;
    if (r_state == S_DIV) begin
      w_nextHi = w_divFits ? w_divDiff : w_divShift[WIDTH-1:0];
      w_nextLo = {r_loPart[WIDTH-2:0], w_divFits};
    end else begin
      w_nextHi = w_mulSum[WIDTH:1];
      w_nextLo = {w_mulSum[0], r_loPart[WIDTH-1:1]};
    end
    w_prod    = {w_nextHi, w_nextLo};
    w_prodFix = r_negRes ? -w_prod : w_prod;
    if (r_state == S_DIV) begin
      w_finalHi = r_negRem ? -w_nextHi : w_nextHi;
      w_finalLo = r_negRes ? -w_nextLo : w_nextLo;
    end else begin
      w_finalHi = w_prodFix[2*WIDTH-1:WIDTH];
      w_finalLo = w_prodFix[WIDTH-1:0];
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:       if (w_accept && w_isLong) w_stateNext = w_isMul ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (w_lastIter) w_stateNext = S_DONE;
      S_DONE:       w_stateNext = S_IDLE;
      default:      w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_hiPart   <= '0;
      r_loPart   <= '0;
      r_opB      <= '0;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_negRes   <= 1'b0;
      r_negRem   <= 1'b0;
    end else if (w_accept) begin
      r_zero <= (a_i == b_i) ^ (op_i == c_opBne);
      if (w_isLong) begin
        r_hiPart   <= '0;
        r_loPart   <= w_isMul ? w_magB : w_magA;
        r_opB      <= w_isMul ? w_magA : w_magB;
        r_negRes   <= w_isSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        r_negRem   <= w_isSigned && w_isDiv && a_i[WIDTH-1];
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
        r_outValid <= 1'b0;
      end else if (w_divZero) begin
        r_hi       <= a_i;
        r_lo       <= '1;
        r_result   <= '1;
        r_ovf      <= 1'b0;
        r_outValid <= 1'b1;
      end else begin
        r_result   <= w_aluRes;
        r_ovf      <= w_aluOvf;
        r_outValid <= 1'b1;
      end
    end else if (w_busy) begin
      r_hiPart <= w_nextHi;
      r_loPart <= w_nextLo;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_lastIter) begin
        r_hi       <= w_finalHi;
        r_lo       <= w_finalLo;
        r_result   <= w_finalLo;
        r_outValid <= 1'b1;
      end
    end else if (r_outValid && out_ready_i) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
